// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I memory-access stage: bus transaction, load formatting, fault detection.
//   in : clk, rst (async, active-high), inValid, memRead, memWrite, funct3, aluOut, storeData,
//        rdIn, regWriteIn, dmemAck, dmemRData
//   out: inReady, dmemReq, dmemWe, dmemAddr, dmemBe, dmemWData, outValid, result, rdOut,
//        regWriteOut, fault, faultCause
module mem_access_stage #(
    parameter int WORD_LEN       = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inValid,
    output logic                inReady,
    input  logic                memRead,
    input  logic                memWrite,
    input  logic [2:0]          funct3,
    input  logic [WORD_LEN-1:0] aluOut,
    input  logic [WORD_LEN-1:0] storeData,
    input  logic [4:0]          rdIn,
    input  logic                regWriteIn,
    output logic                dmemReq,
    output logic                dmemWe,
    output logic [WORD_LEN-1:0] dmemAddr,
    output logic [3:0]          dmemBe,
    output logic [WORD_LEN-1:0] dmemWData,
    input  logic                dmemAck,
    input  logic [WORD_LEN-1:0] dmemRData,
    output logic                outValid,
    output logic [WORD_LEN-1:0] result,
    output logic [4:0]          rdOut,
    output logic                regWriteOut,
    output logic                fault,
    output logic [1:0]          faultCause
);
    typedef enum logic {IDLE, BUS} state_t;
    state_t state;
    logic [1:0]          off_q;
    logic [2:0]          f3_q;
    logic [WORD_LEN-1:0] alu_q;
    logic [4:0]          rd_q;
    logic                rw_q, load_q;
    logic [31:0]         cnt;
    logic                accept, is_mem, word, half, illegal, misal, timeout;
    logic [3:0]          be_n;
    logic [WORD_LEN-1:0] wdata_n, sh, load_val;
    assign inReady = state == IDLE;
    assign accept  = inValid && inReady;
    assign is_mem  = memRead || memWrite;
    // funct3[1] selects a full word, funct3[0] alone a halfword, otherwise a byte
    assign word    = funct3[1];
    assign half    = !funct3[1] && funct3[0];
    assign illegal = (memRead && memWrite) ||
                     (memRead && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)) ||
                     (memWrite && funct3[2]);
    assign misal   = (half && aluOut[0]) || (word && aluOut[1:0] != 2'b00);
    assign be_n    = word ? 4'b1111 : half ? (4'b0011 << {aluOut[1], 1'b0}) : (4'b0001 << aluOut[1:0]);
    assign wdata_n = word ? storeData : half ? {2{storeData[15:0]}} : {4{storeData[7:0]}};
    assign sh      = dmemRData >> {off_q, 3'b000};
    always_comb begin
        load_val = sh;
        case (f3_q)
            3'b000:  load_val = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_val = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_val = {24'd0, sh[7:0]};
            3'b101:  load_val = {16'd0, sh[15:0]};
            default: load_val = sh;
        endcase
    end
    // the counter holds the number of completed BUS cycles, so the edge that would make it
    // reach TIMEOUT_CYCLES is the timeout edge
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == 32'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dmemReq     <= 1'b0;
            dmemWe      <= 1'b0;
            dmemAddr    <= '0;
            dmemBe      <= 4'b0000;
            dmemWData   <= '0;
            outValid    <= 1'b0;
            fault       <= 1'b0;
            faultCause  <= 2'b00;
            result      <= '0;
            rdOut       <= 5'd0;
            regWriteOut <= 1'b0;
            off_q       <= 2'b00;
            f3_q        <= 3'b000;
            alu_q       <= '0;
            rd_q        <= 5'd0;
            rw_q        <= 1'b0;
            load_q      <= 1'b0;
            cnt         <= 32'd0;
        end else begin
            outValid   <= 1'b0;
            fault      <= 1'b0;
            faultCause <= 2'b00;
            if (state == IDLE) begin
                if (accept) begin
                    if (!is_mem || illegal || misal) begin
                        outValid    <= 1'b1;
                        result      <= aluOut;
                        rdOut       <= rdIn;
                        regWriteOut <= !is_mem && regWriteIn;
                        fault       <= is_mem;
                        faultCause  <= !is_mem ? 2'b00 : illegal ? 2'b10 : 2'b01;
                    end else begin
                        state     <= BUS;
                        dmemReq   <= 1'b1;
                        dmemWe    <= memWrite;
                        dmemAddr  <= {aluOut[WORD_LEN-1:2], 2'b00};
                        dmemBe    <= be_n;
                        dmemWData <= memWrite ? wdata_n : '0;
                        off_q     <= aluOut[1:0];
                        f3_q      <= funct3;
                        alu_q     <= aluOut;
                        rd_q      <= rdIn;
                        rw_q      <= regWriteIn;
                        load_q    <= memRead;
                        cnt       <= 32'd0;
                    end
                end
            end else if (dmemAck || timeout) begin
                state       <= IDLE;
                dmemReq     <= 1'b0;
                dmemWe      <= 1'b0;
                outValid    <= 1'b1;
                rdOut       <= rd_q;
                result      <= (dmemAck && load_q) ? load_val : alu_q;
                regWriteOut <= dmemAck && load_q && rw_q;
                fault       <= !dmemAck;
                faultCause  <= dmemAck ? 2'b00 : 2'b11;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0, inReady;
    logic        memRead = 1'b0, memWrite = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] aluOut = '0, storeData = '0;
    logic [4:0]  rdIn = 5'd7;
    logic        regWriteIn = 1'b1;
    logic        dmemReq, dmemWe;
    logic [31:0] dmemAddr, dmemWData, result;
    logic [3:0]  dmemBe;
    logic        dmemAck = 1'b0;
    logic [31:0] dmemRData = '0;
    logic        outValid, regWriteOut, fault;
    logic [4:0]  rdOut;
    logic [1:0]  faultCause;
    int          tests = 0, failed = 0;
    mem_access_stage #(.WORD_LEN(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
        .memRead(memRead), .memWrite(memWrite), .funct3(funct3), .aluOut(aluOut),
        .storeData(storeData), .rdIn(rdIn), .regWriteIn(regWriteIn),
        .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemBe(dmemBe),
        .dmemWData(dmemWData), .dmemAck(dmemAck), .dmemRData(dmemRData),
        .outValid(outValid), .result(result), .rdOut(rdOut), .regWriteOut(regWriteOut),
        .fault(fault), .faultCause(faultCause)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // present one instruction for exactly one accepting edge; returns #1 after that edge
    task automatic issue(input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        memRead = mr; memWrite = mw; funct3 = f3; aluOut = a; storeData = sd; inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    endtask
    task automatic load_ack1(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] rdata, input logic [3:0] be, input logic [31:0] exp);
        issue(1'b1, 1'b0, f3, a, 32'h0);
        dmemAck = 1'b1; dmemRData = rdata;
        @(negedge clk);
        chk({tag, " req"}, 32'(dmemReq), 32'd1);
        chk({tag, " be"}, 32'(dmemBe), 32'(be));
        chk({tag, " addr"}, dmemAddr, {a[31:2], 2'b00});
        chk({tag, " we"}, 32'(dmemWe), 32'd0);
        chk({tag, " wdata"}, dmemWData, 32'h0);
        chk({tag, " early valid"}, 32'(outValid), 32'd0);
        @(posedge clk); #1;
        dmemAck = 1'b0;
        @(negedge clk);
        chk({tag, " valid"}, 32'(outValid), 32'd1);
        chk({tag, " result"}, result, exp);
        chk({tag, " rw"}, 32'(regWriteOut), 32'd1);
        chk({tag, " fault"}, 32'(fault), 32'd0);
        chk({tag, " ready"}, 32'(inReady), 32'd1);
        chk({tag, " req off"}, 32'(dmemReq), 32'd0);
    endtask
    task automatic fault_case(input string tag, input logic [2:0] f3, input logic [31:0] a,
                              input logic [1:0] cause);
        issue(1'b1, 1'b0, f3, a, 32'h0);
        @(negedge clk);
        chk({tag, " req"}, 32'(dmemReq), 32'd0);
        chk({tag, " valid"}, 32'(outValid), 32'd1);
        chk({tag, " fault"}, 32'(fault), 32'd1);
        chk({tag, " cause"}, 32'(faultCause), 32'(cause));
        chk({tag, " rw"}, 32'(regWriteOut), 32'd0);
        chk({tag, " result"}, result, a);
    endtask
    initial begin
        @(negedge clk);
        chk("reset ready", 32'(inReady), 32'd1);
        chk("reset req", 32'(dmemReq), 32'd0);
        chk("reset valid", 32'(outValid), 32'd0);
        chk("reset result", result, 32'h0);
        chk("reset be", 32'(dmemBe), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        // non-memory back-to-back
        inValid = 1'b1; aluOut = 32'h11; rdIn = 5'd3;
        @(posedge clk); #1 aluOut = 32'h22;
        @(negedge clk);
        chk("alu0 valid", 32'(outValid), 32'd1);
        chk("alu0 result", result, 32'h11);
        chk("alu0 req", 32'(dmemReq), 32'd0);
        @(posedge clk); #1 aluOut = 32'h33;
        @(negedge clk);
        chk("alu1 valid", 32'(outValid), 32'd1);
        chk("alu1 result", result, 32'h22);
        chk("alu1 req", 32'(dmemReq), 32'd0);
        @(posedge clk); #1 inValid = 1'b0;
        @(negedge clk);
        chk("alu2 valid", 32'(outValid), 32'd1);
        chk("alu2 result", result, 32'h33);
        chk("alu2 rd", 32'(rdOut), 32'd3);
        chk("alu2 rw", 32'(regWriteOut), 32'd1);
        chk("alu2 req", 32'(dmemReq), 32'd0);
        @(negedge clk);
        chk("alu idle valid", 32'(outValid), 32'd0);
        // loads with immediate ack
        load_ack1("lb", 3'b000, 32'h1003, 32'h80FF_0000, 4'b1000, 32'hFFFF_FF80);
        load_ack1("lbu", 3'b100, 32'h1003, 32'h80FF_0000, 4'b1000, 32'h0000_0080);
        load_ack1("lh", 3'b001, 32'h8002, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
        load_ack1("lhu", 3'b101, 32'h8000, 32'h1234_9abc, 4'b0011, 32'h0000_9abc);
        load_ack1("lw", 3'b010, 32'h9004, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
        // SH with three wait cycles; ack lands on the timeout edge and must win
        issue(1'b0, 1'b1, 3'b001, 32'h2002, 32'hDEAD_BEEF);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) dmemAck = 1'b1;
            @(negedge clk);
            chk("sh ready low", 32'(inReady), 32'd0);
            chk("sh req", 32'(dmemReq), 32'd1);
            chk("sh no valid", 32'(outValid), 32'd0);
            @(posedge clk); #1;
        end
        dmemAck = 1'b0;
        chk("sh be", 32'(dmemBe), 32'(4'b1100));
        chk("sh wdata", dmemWData, 32'hBEEF_BEEF);
        @(negedge clk);
        chk("sh valid", 32'(outValid), 32'd1);
        chk("sh fault", 32'(fault), 32'd0);
        chk("sh rw", 32'(regWriteOut), 32'd0);
        chk("sh result", result, 32'h2002);
        chk("sh ready", 32'(inReady), 32'd1);
        // SB lane replication and byte enable
        issue(1'b0, 1'b1, 3'b000, 32'h7001, 32'h0000_00A5);
        @(negedge clk);
        chk("sb be", 32'(dmemBe), 32'(4'b0010));
        chk("sb wdata", dmemWData, 32'hA5A5_A5A5);
        chk("sb we", 32'(dmemWe), 32'd1);
        chk("sb addr", dmemAddr, 32'h7000);
        dmemAck = 1'b1;
        @(posedge clk); #1 dmemAck = 1'b0;
        @(negedge clk);
        chk("sb valid", 32'(outValid), 32'd1);
        // faults
        fault_case("lw misaligned", 3'b010, 32'h3001, 2'b01);
        fault_case("lh misaligned", 3'b001, 32'h3003, 2'b01);
        fault_case("ld illegal", 3'b011, 32'h3000, 2'b10);
        // timeout: request held four cycles, then a cause-11 fault
        issue(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("to req", 32'(dmemReq), 32'd1);
            chk("to no valid", 32'(outValid), 32'd0);
        end
        @(negedge clk);
        chk("to req off", 32'(dmemReq), 32'd0);
        chk("to valid", 32'(outValid), 32'd1);
        chk("to fault", 32'(fault), 32'd1);
        chk("to cause", 32'(faultCause), 32'd3);
        chk("to rw", 32'(regWriteOut), 32'd0);
        chk("to result", result, 32'h4000);
        // reset in the middle of a bus wait
        issue(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rst pre req", 32'(dmemReq), 32'd1);
        #1 rst = 1'b1;
        #1 chk("rst async req", 32'(dmemReq), 32'd0);
        chk("rst valid", 32'(outValid), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst post valid", 32'(outValid), 32'd0);
        chk("rst post ready", 32'(inReady), 32'd1);
        load_ack1("lw after rst", 3'b010, 32'h6000, 32'h1234_5678, 4'b1111, 32'h1234_5678);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
